// File: rtl/dvs_aer_event_rx_pkg.sv
// Shared types and constants for the DVS AER event receiver.
//  - Default address/timestamp widths and the packed event width.
//  - dvs_event_t : {ts, x, y, pol}, MSB first, exactly as written to the FIFO bus.
//  - aer_rx_state_e : camera-side handshake FSM states.
//  - sat_inc16 : saturating 16-bit increment used by the drop counter.
`timescale 1ns/1ps
package dvs_ravens_pkg;

    localparam int TIMESTAMP_US_BITS = 32;
    localparam int DVS_X_BITS        = 9;
    localparam int DVS_Y_BITS        = 9;
    localparam int EVENT_BITS        = TIMESTAMP_US_BITS + DVS_X_BITS + DVS_Y_BITS + 1;

    typedef struct packed {
        logic [TIMESTAMP_US_BITS-1:0] ts;
        logic [DVS_X_BITS-1:0]        x;
        logic [DVS_Y_BITS-1:0]        y;
        logic                         pol;
    } dvs_event_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_LATCH      = 3'd2,
        ST_WAIT_SPACE = 3'd3,
        ST_ACK_HI     = 3'd4,
        ST_ACK_LO     = 3'd5
    } aer_rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dvs_aer_event_rx_if.sv
// Bus bundle for the DVS AER receiver.
//  Camera side : aer, xsel, req (to receiver), ack (from receiver).
//  FIFO side   : fifo_grant (to receiver), fifo_req, fifo_wr_en, fifo_event (from receiver).
//  modport slave  : the receiver.
//  modport master : the environment (camera + FIFO arbiter).
`timescale 1ns/1ps
interface dvs_aer_event_rx_if
    import dvs_ravens_pkg::*;
#(
    parameter int AER_BITS = 10,
    parameter int EVT_W    = EVENT_BITS
);
    logic [AER_BITS-1:0] aer;
    logic                xsel;
    logic                req;
    logic                ack;
    logic                fifo_req;
    logic                fifo_grant;
    logic                fifo_wr_en;
    logic [EVT_W-1:0]    fifo_event;

    modport slave (
        input  aer, xsel, req, fifo_grant,
        output ack, fifo_req, fifo_wr_en, fifo_event
    );

    modport master (
        output aer, xsel, req, fifo_grant,
        input  ack, fifo_req, fifo_wr_en, fifo_event
    );
endinterface

// File: rtl/dvs_aer_event_rx_evq.sv
// dvs_evq: synchronous event queue of dvs_event_t.
//  clk, rst_n : clock, async active-low reset (flushes the queue)
//  push, din  : write request and data (ignored when full)
//  pop        : read request (ignored when empty); dout is the current head
//  full/empty : derived from the registered level
//  level      : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
`timescale 1ns/1ps
module dvs_evq
    import dvs_ravens_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  dvs_event_t               din,
    input  logic                     pop,
    output dvs_event_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    dvs_event_t        mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: rtl/dvs_aer_event_rx.sv
// dvs_aer_event_rx: DVS AER receiver.
//  Completes the 4-phase AER handshake with the camera, pairs each X word with the
//  last Y word into a timestamped event, queues events, and drains the queue onto a
//  shared FIFO bus by req/grant (at most one write every 3 clocks).
// Ports:
//  clk, rst_n  : system clock, asynchronous active-low reset
//  bus (slave) : aer/xsel/req/ack camera handshake, fifo_req/fifo_grant/fifo_wr_en/fifo_event
//  time_us     : free-running microsecond time, sampled in the push cycle
//  drop_cnt    : saturating count of X words dropped for lack of a Y word
//  evq_level   : event queue occupancy
// Optional build macro DVS_ROI_FILTER_EN: X words outside the inclusive ROI
//  (ROI_X_MIN..ROI_X_MAX, ROI_Y_MIN..ROI_Y_MAX) are acked and discarded silently.
`timescale 1ns/1ps
module dvs_aer_event_rx
    import dvs_ravens_pkg::*;
#(
    parameter int AER_BITS        = 10,
    parameter int X_BITS          = DVS_X_BITS,
    parameter int Y_BITS          = DVS_Y_BITS,
    parameter int TS_BITS         = TIMESTAMP_US_BITS,
    parameter int Y_SETTLE_CYCLES = 5,
    parameter int EVQ_DEPTH       = 8
`ifdef DVS_ROI_FILTER_EN
    ,
    parameter int ROI_X_MIN = 0,
    parameter int ROI_X_MAX = (1 << X_BITS) - 1,
    parameter int ROI_Y_MIN = 0,
    parameter int ROI_Y_MAX = (1 << Y_BITS) - 1
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dvs_aer_event_rx_if.slave           bus,
    input  logic [TS_BITS-1:0]          time_us,
    output logic [15:0]                 drop_cnt,
    output logic [$clog2(EVQ_DEPTH):0]  evq_level
);
    localparam int CNT_W = $clog2(Y_SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(Y_SETTLE_CYCLES - 1);

    logic               req_meta_r;
    logic               req_s_r;
    aer_rx_state_e      state_r;
    aer_rx_state_e      state_nx_s;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic [Y_BITS-1:0]  y_reg_r;
    logic               y_valid_r;
    logic [AER_BITS-1:0] aer_lat_r;
    logic [AER_BITS-1:0] aer_src_s;
    logic [15:0]        drop_cnt_r;
    logic               ack_r;
    logic               ack_nx_s;
    logic               y_load_s;
    logic               drop_s;
    logic               push_s;
    logic               roi_ok_s;
    dvs_event_t         push_data_s;
    dvs_event_t         evq_head_s;
    logic               evq_full_s;
    logic               evq_empty_s;
    logic               pop_s;
    logic               fifo_req_r;
    logic               fifo_wr_en_r;
    dvs_event_t         fifo_event_r;

    assign bus.ack        = ack_r;
    assign bus.fifo_req   = fifo_req_r;
    assign bus.fifo_wr_en = fifo_wr_en_r;
    assign bus.fifo_event = fifo_event_r;
    assign drop_cnt       = drop_cnt_r;

    // Two-flop synchroniser for the asynchronous camera request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_r <= 1'b0;
            req_s_r    <= 1'b0;
        end else begin
            req_meta_r <= bus.req;
            req_s_r    <= req_meta_r;
        end
    end

`ifdef DVS_ROI_FILTER_EN
    localparam logic [X_BITS-1:0] ROI_XL = X_BITS'(ROI_X_MIN);
    localparam logic [X_BITS-1:0] ROI_XH = X_BITS'(ROI_X_MAX);
    localparam logic [Y_BITS-1:0] ROI_YL = Y_BITS'(ROI_Y_MIN);
    localparam logic [Y_BITS-1:0] ROI_YH = Y_BITS'(ROI_Y_MAX);
    // Region-of-interest test on the X word being latched and the held Y.
    always_comb begin
        roi_ok_s = (bus.aer[X_BITS:1] >= ROI_XL) && (bus.aer[X_BITS:1] <= ROI_XH) &&
                   (y_reg_r >= ROI_YL) && (y_reg_r <= ROI_YH);
    end
`else
    // Without the ROI filter every paired X word is accepted.
    always_comb begin
        roi_ok_s = 1'b1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s_r) state_nx_s = ST_SETTLE;
                else         state_nx_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == {CNT_W{1'b0}}) state_nx_s = ST_LATCH;
                else                               state_nx_s = ST_SETTLE;
            end
            ST_LATCH: begin
                // Only a pairable, in-ROI X word can be held back by a full queue.
                if (bus.xsel && y_valid_r && roi_ok_s && evq_full_s) state_nx_s = ST_WAIT_SPACE;
                else                                                 state_nx_s = ST_ACK_HI;
            end
            ST_WAIT_SPACE: begin
                if (!evq_full_s) state_nx_s = ST_ACK_HI;
                else             state_nx_s = ST_WAIT_SPACE;
            end
            ST_ACK_HI: begin
                if (!req_s_r) state_nx_s = ST_ACK_LO;
                else          state_nx_s = ST_ACK_HI;
            end
            ST_ACK_LO: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output decode: Y load, drop, push, event assembly and next ack.
    always_comb begin
        y_load_s  = 1'b0;
        drop_s    = 1'b0;
        push_s    = 1'b0;
        aer_src_s = aer_lat_r;
        case (state_r)
            ST_LATCH: begin
                aer_src_s = bus.aer;
                y_load_s  = !bus.xsel;
                drop_s    = bus.xsel && !y_valid_r;
                push_s    = bus.xsel && y_valid_r && roi_ok_s && !evq_full_s;
            end
            ST_WAIT_SPACE: begin
                push_s = !evq_full_s;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
        push_data_s.ts  = time_us;
        push_data_s.x   = aer_src_s[X_BITS:1];
        push_data_s.y   = y_reg_r;
        push_data_s.pol = aer_src_s[0];
        // ack is registered: it is high exactly while the FSM sits in ACK_HI.
        ack_nx_s = (state_nx_s == ST_ACK_HI);
    end

    // Settle counter: loaded on request detection, counts down through SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && req_s_r) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r != {CNT_W{1'b0}})) begin
            settle_cnt_r <= settle_cnt_r - CNT_W'(1);
        end
    end

    // Y word holding register, AER capture for a stalled push, drop counter and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg_r    <= {Y_BITS{1'b0}};
            y_valid_r  <= 1'b0;
            aer_lat_r  <= {AER_BITS{1'b0}};
            drop_cnt_r <= 16'd0;
            ack_r      <= 1'b0;
        end else begin
            if (y_load_s) begin
                y_reg_r   <= bus.aer[Y_BITS-1:0];
                y_valid_r <= 1'b1;
            end
            if (state_r == ST_LATCH) begin
                aer_lat_r <= bus.aer;
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
            ack_r <= ack_nx_s;
        end
    end

    dvs_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (evq_head_s),
        .full  (evq_full_s),
        .empty (evq_empty_s),
        .level (evq_level)
    );

    assign pop_s = fifo_req_r && bus.fifo_grant;

    // FIFO-bus side: grant pops the head into the output register; fifo_req stays low
    // in the write cycle and the one after, giving at most one write every 3 clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_req_r   <= 1'b0;
            fifo_wr_en_r <= 1'b0;
            fifo_event_r <= '0;
        end else begin
            fifo_req_r   <= !evq_empty_s && !pop_s && !fifo_wr_en_r;
            fifo_wr_en_r <= pop_s;
            if (pop_s) begin
                fifo_event_r <= evq_head_s;
            end
        end
    end
endmodule

// File: tb/tb_dvs_aer_event_rx.sv
`timescale 1ns/1ps
module tb_dvs_aer_event_rx;
    import dvs_ravens_pkg::*;

    localparam int CLK_P = 10;
`ifdef DVS_ROI_FILTER_EN
    localparam int RX_MIN = 10;
    localparam int RX_MAX = 20;
`else
    localparam int RX_MIN = 0;
    localparam int RX_MAX = 511;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] time_us;
    logic [15:0] drop_cnt;
    logic [3:0]  evq_level;

    dvs_aer_event_rx_if #(.AER_BITS(10), .EVT_W(EVENT_BITS)) bus ();

`ifdef DVS_ROI_FILTER_EN
    dvs_aer_event_rx #(.ROI_X_MIN(10), .ROI_X_MAX(20)) u_dut (
`else
    dvs_aer_event_rx u_dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .time_us   (time_us),
        .drop_cnt  (drop_cnt),
        .evq_level (evq_level)
    );

    always #(CLK_P/2) clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    dvs_event_t  exp_q[$];
    logic [8:0]  m_y;
    bit          m_yv;
    int          m_drop;
    int          grant_mode = 0;
    int          wr_cnt = 0;
    longint      cyc = 0;
    longint      last_wr = 0;
    bit          have_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural model: what one completed camera word does to the receiver.
    task automatic model_word(input logic xs, input logic [9:0] a, input logic [31:0] ts);
        dvs_event_t ev;
        if (!xs) begin
            m_y  = a[8:0];
            m_yv = 1'b1;
        end else if (!m_yv) begin
            if (m_drop < 65535) m_drop++;
        end else if (int'(a[9:1]) >= RX_MIN && int'(a[9:1]) <= RX_MAX) begin
            ev.ts = ts; ev.x = a[9:1]; ev.y = m_y; ev.pol = a[0];
            exp_q.push_back(ev);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        bus.fifo_grant = 1'b0;
        forever begin
            @(negedge clk);
            case (grant_mode)
                0:       bus.fifo_grant = 1'b0;
                1:       bus.fifo_grant = 1'($urandom_range(0, 1));
                default: bus.fifo_grant = 1'b1;
            endcase
        end
    end

    // Scoreboard: every write strobe must carry the oldest expected event.
    initial forever begin
        dvs_event_t ev;
        @(negedge clk);
        if (rst_n && bus.fifo_wr_en) begin
            check("req_low_in_wr", 64'(bus.fifo_req), 64'd0);
            if (have_last) check("wr_spacing_ge3", 64'((cyc - last_wr) >= 64'd3), 64'd1);
            last_wr = cyc; have_last = 1'b1; wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event actual=%0h required=none", bus.fifo_event);
            end else begin
                ev = exp_q.pop_front();
                check("event", 64'(bus.fifo_event), 64'(ev));
            end
        end
    end

    initial begin
        #500us;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic do_reset();
        rst_n = 1'b0; bus.req = 1'b0;
        exp_q.delete(); m_yv = 1'b0; m_drop = 0; have_last = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input logic lvl, input int bound, input string name);
        int n = 0;
        while (bus.ack !== lvl && n < bound) begin
            @(negedge clk); n++;
        end
        check(name, 64'(bus.ack), 64'(lvl));
    endtask

    task automatic send_word(input logic xs, input logic [9:0] a, input logic [31:0] ts,
                             output longint lat);
        time t0;
        @(negedge clk);
        bus.xsel = xs; bus.aer = a; time_us = ts; bus.req = 1'b1; t0 = $time;
        wait_ack(1'b1, 3000, "ack_seen");
        lat = longint'($time - t0);
        model_word(xs, a, ts);
        bus.req = 1'b0;
        wait_ack(1'b0, 100, "ack_release");
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || evq_level != 4'd0) && n < 5000) begin
            @(negedge clk); n++;
        end
        check("drain_model_empty", 64'(exp_q.size()), 64'd0);
        check("drain_level", 64'(evq_level), 64'd0);
    endtask

    initial begin
        longint     lat;
        int         w0, n;
        bit         seen;
        dvs_event_t lit;
        longint     wc[$];
        bus.req = 1'b0; bus.xsel = 1'b0; bus.aer = 10'd0; time_us = 32'd0;
        m_drop = 0; m_yv = 1'b0; m_y = 9'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_fifo_req", 64'(bus.fifo_req), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        check("rst_event", 64'(bus.fifo_event), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_level", 64'(evq_level), 64'd0);

        // Lone X word after reset: acked, dropped, nothing requested on the FIFO bus
        send_word(1'b1, {9'd7, 1'b1}, 32'h55, lat);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.fifo_req) seen = 1'b1; end
        check("lone_x_no_fifo_req", 64'(seen), 64'd0);
        check("lone_x_drop", 64'(drop_cnt), 64'd1);

        // Directed event: Y=0x12A, X=0x05 pol=1 at time 0x100
        do_reset();
        grant_mode = 2;
        send_word(1'b0, 10'h12A, 32'h0, lat);
        check("y_latch_ge_50ns", 64'((lat - longint'(CLK_P/2)) >= 64'd50), 64'd1);
        send_word(1'b1, {9'h05, 1'b1}, 32'h100, lat);
        lit.ts = 32'h100; lit.x = 9'h05; lit.y = 9'h12A; lit.pol = 1'b1;
        n = 0;
        while (!bus.fifo_wr_en && n < 100) begin @(negedge clk); n++; end
        check("directed_event", 64'(bus.fifo_event), 64'(lit));
        wait_drain();

        // Y=3 then 10 X words with grant held low: back-pressure at 8
        do_reset();
        grant_mode = 0;
        w0 = wr_cnt;
        send_word(1'b0, 10'd3, 32'h0, lat);
        for (int i = 0; i < 8; i++) send_word(1'b1, 10'(i * 6 + 1), 32'(1000 + i), lat);
        check("level_full", 64'(evq_level), 64'd8);
        fork
            begin
                longint l9;
                send_word(1'b1, 10'h3F0, 32'd2000, l9);
            end
        join_none
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.ack) seen = 1'b1; end
        check("ninth_blocked", 64'(seen), 64'd0);
        grant_mode = 2;
        n = 0;
        while (!bus.fifo_wr_en && n < 50) begin @(negedge clk); n++; end
        grant_mode = 0;
        wait fork;
        check("level_refull", 64'(evq_level), 64'd8);
        grant_mode = 1;
        send_word(1'b1, 10'h2AA, 32'd3000, lat);
        wait_drain();
        check("ten_events_out", 64'(wr_cnt - w0), 64'd10);

        // Grant tied high with 3 queued events: writes exactly 3 clocks apart
        do_reset();
        grant_mode = 0;
        send_word(1'b0, 10'h1C4, 32'h0, lat);
        for (int i = 0; i < 3; i++) send_word(1'b1, 10'(100 + i), 32'(i), lat);
        grant_mode = 2;
        repeat (40) begin @(negedge clk); if (bus.fifo_wr_en) wc.push_back(cyc); end
        check("tied_count", 64'(wc.size()), 64'd3);
        check("tied_gap1", 64'((wc.size() >= 2) ? (wc[1] - wc[0]) : 0), 64'd3);
        check("tied_gap2", 64'((wc.size() >= 3) ? (wc[2] - wc[1]) : 0), 64'd3);
        wait_drain();

        // Reset pulse during ACK_HI with queued events and a nonzero drop count
        do_reset();
        grant_mode = 0;
        send_word(1'b1, 10'h011, 32'h0, lat);
        send_word(1'b0, 10'h055, 32'h0, lat);
        send_word(1'b1, 10'h123, 32'h7, lat);
        send_word(1'b1, 10'h0F2, 32'h8, lat);
        @(negedge clk);
        bus.xsel = 1'b0; bus.aer = 10'h0AB; bus.req = 1'b1;
        wait_ack(1'b1, 3000, "pre_reset_ack");
        #2;
        rst_n = 1'b0;
        exp_q.delete(); m_yv = 1'b0; m_drop = 0; have_last = 1'b0;
        #1;
        check("mid_rst_ack", 64'(bus.ack), 64'd0);
        check("mid_rst_fifo_req", 64'(bus.fifo_req), 64'd0);
        check("mid_rst_level", 64'(evq_level), 64'd0);
        check("mid_rst_drop", 64'(drop_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(1'b1, 3000, "post_reset_ack");
        model_word(1'b0, 10'h0AB, 32'h0);
        bus.req = 1'b0;
        wait_ack(1'b0, 100, "post_reset_release");
        grant_mode = 1;
        send_word(1'b1, 10'h099, 32'h42, lat);
        wait_drain();

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ((i % 40) == 0) grant_mode = int'($urandom_range(1, 2));
            send_word(1'($urandom_range(0, 3) != 0), 10'($urandom), $urandom, lat);
        end
        wait_drain();
        check("random_drop", 64'(drop_cnt), 64'(m_drop));

`ifdef DVS_ROI_FILTER_EN
        // ROI x 10..20: only x=10 emitted, drop count untouched
        do_reset();
        grant_mode = 2;
        w0 = wr_cnt;
        send_word(1'b0, 10'd5, 32'h0, lat);
        send_word(1'b1, {9'd9, 1'b0}, 32'h1, lat);
        send_word(1'b1, {9'd10, 1'b1}, 32'h2, lat);
        send_word(1'b1, {9'd21, 1'b0}, 32'h3, lat);
        wait_drain();
        check("roi_count", 64'(wr_cnt - w0), 64'd1);
        check("roi_drop", 64'(drop_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
